// File: rtl/rgb_mixer_pkg.sv
// rgb_mixer_pkg: constants shared by the RGB mixer encoder and PWM stages.
//   ENC_WIDTH            - level register width, also used by the PWM stage
//   DEBOUNCE_DIV_DEFAULT - default clk cycles between debounce strobes
//   STABLE_CNT_DEFAULT   - default identical strobe samples to accept a level
package rgb_mixer_pkg;
   localparam int ENC_WIDTH            = 8;
   localparam int DEBOUNCE_DIV_DEFAULT = 16;
   localparam int STABLE_CNT_DEFAULT   = 3;
endpackage

// File: rtl/encoder_debounce.sv
// encoder_debounce: 2-flop synchroniser plus strobe-sampled stability filter for one raw input.
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   strobe    - one-cycle debounce sample strobe from the shared prescaler
//   raw       - raw input, asynchronous to clk
//   debounced - filtered level, changes only after STABLE_CNT agreeing strobes
module encoder_debounce #(
   parameter int STABLE_CNT = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic strobe,
   input  logic raw,
   output logic debounced
);
   localparam int CW = $clog2(STABLE_CNT);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);
   logic          r_s1;
   logic          r_s2;
   logic          r_deb;
   logic [CW-1:0] r_cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_deb <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_s1 <= raw;
         r_s2 <= r_s1;
         // any strobe that sees agreement restarts the count, so only an
         // uninterrupted run of STABLE_CNT differing samples flips the level
         if (strobe) begin
            if (r_s2 != r_deb) begin
               if (r_cnt == LAST) begin
                  r_deb <= r_s2;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end else begin
               r_cnt <= '0;
            end
         end
      end
   end
   assign debounced = r_deb;
endmodule

// File: rtl/encoder_channel.sv
// encoder_channel: rotary encoder front end for one colour channel; debounces A/B and tracks the level.
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   enc_a     - raw encoder A, asynchronous to clk
//   enc_b     - raw encoder B, asynchronous to clk
//   value     - current WIDTH-bit level for the PWM compare
//   step_up   - one-cycle pulse in the cycle value shows an increment
//   step_down - one-cycle pulse in the cycle value shows a decrement
// Build option: define ENC_SATURATE_EN to clamp value at 0 and 2^WIDTH-1
// instead of wrapping; a clamped count produces no step pulse.
module encoder_channel
   import rgb_mixer_pkg::*;
#(
   parameter int WIDTH        = ENC_WIDTH,
   parameter int DEBOUNCE_DIV = DEBOUNCE_DIV_DEFAULT,
   parameter int STABLE_CNT   = STABLE_CNT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enc_a,
   input  logic             enc_b,
   output logic [WIDTH-1:0] value,
   output logic             step_up,
   output logic             step_down
);
   localparam int DW = $clog2(DEBOUNCE_DIV);
   localparam logic [DW-1:0]    DIV_LAST = DW'(DEBOUNCE_DIV - 1);
   localparam logic [WIDTH-1:0] MAX_VAL  = '1;
   logic [DW-1:0]    r_div;
   logic             r_prev_a;
   logic [WIDTH-1:0] r_value;
   logic             r_step_up;
   logic             r_step_down;
   logic             w_strobe;
   logic             w_a;
   logic             w_b;
   logic             w_rise;
   logic             w_inc;
   logic             w_dec;
   assign w_strobe = (r_div == DIV_LAST);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_div <= '0;
      else        r_div <= w_strobe ? '0 : r_div + 1'b1;
   end
   encoder_debounce #(.STABLE_CNT(STABLE_CNT)) u_deb_a (
      .clk(clk), .rst_n(rst_n), .strobe(w_strobe), .raw(enc_a), .debounced(w_a)
   );
   encoder_debounce #(.STABLE_CNT(STABLE_CNT)) u_deb_b (
      .clk(clk), .rst_n(rst_n), .strobe(w_strobe), .raw(enc_b), .debounced(w_b)
   );
   // the rise is seen the cycle after A's debounced update, so B is already
   // post-update when both flip on the same strobe
   assign w_rise = w_a & ~r_prev_a;
`ifdef ENC_SATURATE_EN
   assign w_inc = w_rise & ~w_b & (r_value != MAX_VAL);
   assign w_dec = w_rise &  w_b & (r_value != '0);
`else
   assign w_inc = w_rise & ~w_b;
   assign w_dec = w_rise &  w_b;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_a    <= 1'b0;
         r_value     <= '0;
         r_step_up   <= 1'b0;
         r_step_down <= 1'b0;
      end else begin
         r_prev_a    <= w_a;
         r_value     <= w_inc ? r_value + 1'b1 : w_dec ? r_value - 1'b1 : r_value;
         r_step_up   <= w_inc;
         r_step_down <= w_dec;
      end
   end
   assign value     = r_value;
   assign step_up   = r_step_up;
   assign step_down = r_step_down;
endmodule

// File: tb/tb_encoder_channel.sv
// tb_encoder_channel: directed encoder stimulus checked against a detent-level model.
module tb_encoder_channel;
   localparam int LAT = 2 + 3 * 4 + 1;
   typedef struct {
      bit up;
      int val;
      int t;
   } ev_t;
   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       enc_a = 1'b0;
   logic       enc_b = 1'b0;
   logic [7:0] value;
   logic       step_up;
   logic       step_down;
   int         vectors     = 0;
   int         miscompares = 0;
   int         cyc         = 0;
   int         m_val       = 0;
   int         exp_val     = 0;
   int         n_up        = 0;
   int         n_dn        = 0;
   ev_t        q[$];
   ev_t        e;
   always #5 clk = ~clk;
   encoder_channel #(.WIDTH(8), .DEBOUNCE_DIV(4), .STABLE_CNT(3)) dut (
      .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
      .value(value), .step_up(step_up), .step_down(step_down)
   );
   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_val   = 0;
      exp_val = 0;
      q.delete();
   endtask
   // one accepted A rise: up when B is low, else down
   task automatic model_rise();
      bit up;
      int nv;
      up = !enc_b;
      nv = up ? m_val + 1 : m_val - 1;
`ifdef ENC_SATURATE_EN
      if (nv < 0 || nv > 255) return;
`else
      nv = (nv + 256) % 256;
`endif
      m_val = nv;
      q.push_back('{up, nv, cyc});
   endtask
   always @(posedge clk) begin
      #1;
      cyc++;
      if (rst_n) begin
         chk("exclusive_steps", int'(step_up && step_down), 0);
         if (step_up || step_down) begin
            if (step_up) n_up++;
            else         n_dn++;
            if (q.size() == 0) begin
               chk("unexpected_step_queue", q.size(), 1);
            end else begin
               e = q.pop_front();
               chk("step_dir_up", int'(step_up), int'(e.up));
               chk("step_value", int'(value), e.val);
               vectors++;
               if (cyc - e.t > LAT) begin
                  miscompares++;
                  $display("FAIL latency: got %0d cycles, required <= %0d", cyc - e.t, LAT);
               end
               exp_val = e.val;
            end
         end else begin
            chk("hold_value", int'(value), exp_val);
            if (q.size() > 0 && cyc - q[0].t > LAT) begin
               chk("step_timeout_cycles", cyc - q[0].t, LAT);
               e = q.pop_front();
            end
         end
      end
   end
   task automatic drive(input bit a, input bit b, input int hold);
      bit rise;
      rise  = a && !enc_a;
      enc_a = a;
      enc_b = b;
      if (rise) model_rise();
      repeat (hold) @(negedge clk);
   endtask
   task automatic detent_cw(input int h);
      drive(1, 0, h);
      drive(1, 1, h);
      drive(0, 1, h);
      drive(0, 0, h);
   endtask
   task automatic detent_ccw(input int h);
      drive(0, 1, h);
      drive(1, 1, h);
      drive(1, 0, h);
      drive(0, 0, h);
   endtask
   task automatic reset_dut();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n_up = 0;
      n_dn = 0;
      repeat (2) @(negedge clk);
   endtask
   initial begin
      int wexp[3];
`ifdef ENC_SATURATE_EN
      wexp = '{255, 255, 255};
`else
      wexp = '{255, 0, 1};
`endif
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         enc_a = i[0];
         enc_b = i[1];
      end
      @(negedge clk);
      enc_a = 1'b0;
      enc_b = 1'b0;
      model_reset();
      rst_n = 1'b1;
      chk("reset_value", int'(value), 0);
      chk("reset_step_up", int'(step_up), 0);
      chk("reset_step_down", int'(step_down), 0);
      repeat (30) @(negedge clk);
      chk("post_reset_value", int'(value), 0);
      repeat (5) detent_cw(20);
      chk("pre_async_value", int'(value), 5);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_value", int'(value), 0);
      chk("async_reset_steps", int'(step_up || step_down), 0);
      model_reset();
      @(negedge clk);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n_up = 0;
      n_dn = 0;
      repeat (2) @(negedge clk);
      repeat (10) detent_cw(20);
      chk("cw_value", int'(value), 10);
      chk("cw_up_pulses", n_up, 10);
      chk("cw_down_pulses", n_dn, 0);
      reset_dut();
      repeat (3) detent_ccw(20);
`ifdef ENC_SATURATE_EN
      chk("ccw_value", int'(value), 0);
      chk("ccw_down_pulses", n_dn, 0);
`else
      chk("ccw_value", int'(value), 253);
      chk("ccw_down_pulses", n_dn, 3);
`endif
      chk("ccw_up_pulses", n_up, 0);
      reset_dut();
`ifdef ENC_SATURATE_EN
      repeat (254) detent_cw(16);
`else
      repeat (2) detent_ccw(20);
`endif
      chk("preload_value", int'(value), 254);
      for (int i = 0; i < 3; i++) begin
         detent_cw(20);
         chk($sformatf("wrap_up_%0d", i), int'(value), wexp[i]);
      end
      reset_dut();
      enc_a = 1'b1;
      repeat (8) @(negedge clk);
      enc_a = 1'b0;
      repeat (40) @(negedge clk);
      chk("glitch_value", int'(value), 0);
      drive(1, 0, 20);
      chk("long_high_value", int'(value), 1);
      drive(0, 0, 20);
      n_up = 0;
      for (int i = 0; i < 5; i++) begin
         enc_a = 1'b1;
         repeat (3) @(negedge clk);
         enc_a = 1'b0;
         repeat (3) @(negedge clk);
      end
      drive(1, 0, 30);
      drive(0, 0, 30);
      chk("bounce_up_pulses", n_up, 1);
      chk("bounce_value", int'(value), 2);
      chk("model_queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
      $fatal(1, "watchdog");
   end
endmodule
